ucode_mul_seq: RTL and testbench
================================

Name: ucode_mul_seq

Overview:
- Parametrised microcode sequencer that expands `MUL Rd, Rs, #imm` into a stream of simple ALU instructions injected into the pipeline in place of the IF stream.
- Uses shift-and-add over a reserved scratch register, so cost is O(IMM_W) instructions rather than O(imm).
- Has valid/ready handshakes on both sides, so pipeline stalls are honoured.
- Sits between the ID stage (which issues the request) and the IF/ID instruction mux (which it drives).

Parameters:
- IMM_W, 16, width of the multiplier immediate.
- REG_W, 4, width of a register index.
- INSN_W, 32, instruction word width.
- SCRATCH_REG, 15, register index reserved for the shifted multiplicand T.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  ID presents a decoded MUL
- req_ready  out  1  sequencer can accept; high only in IDLE
- dest_reg  in  REG_W  Rd, sampled on accept
- source_reg  in  REG_W  Rs, sampled on accept
- immediate  in  IMM_W  multiplier, sampled on accept
- out_insn  out  INSN_W  generated instruction; NOP when out_valid=0
- out_valid  out  1  out_insn is a real instruction
- out_ready  in  1  pipeline accepts out_insn this cycle (low = stall)
- mux_sel  out  1  1 = pipeline takes out_insn instead of fetch
- done  out  1  one-cycle pulse when the sequence completes
- err  out  1  one-cycle pulse: request rejected (Rd or Rs == SCRATCH_REG)

Behaviour:
- Reset values: state IDLE; out_valid=0; out_insn=NOP; mux_sel=0; done=0; err=0; req_ready=1 (in IDLE).
- Reset is asynchronous and aborts any sequence in flight. The partially modified Rd is not restored.
- Accept = req_valid && req_ready. Rd, Rs and imm are latched into registers d_q, s_q, imm_q. All later outputs use only the latched copies.
- First out_valid appears the cycle after accept.
- Each emitting state holds out_insn and out_valid stable until out_ready=1, then advances. While out_ready=0 nothing changes.
- mux_sel = 1 in every state except IDLE and FIN.
- States and emitted instructions (T = SCRATCH_REG):
  - IDLE: if accepted with Rd or Rs == T, go to FIN with err flagged. Else if imm == 0, go to CLRD. Else go to CLRT.
  - CLRT: emit MOV T,#0; then go to CPYT.
  - CPYT: emit ADD T,T,Rs; then go to CLRD. Copying Rs into T first makes Rd == Rs aliasing safe.
  - CLRD: emit MOV Rd,#0. Then go to FIN if imm_q == 0; else ADD if imm_q[0] == 1; else SHL.
  - ADD: emit ADD Rd,Rd,T. Then go to FIN if imm_q[IMM_W-1:1] == 0; else SHL.
  - SHL: emit LSL T,T,#1 and shift imm_q right by 1. Then go to ADD if the new bit 0 == 1; else stay in SHL.
  - FIN: out_valid=0; done=1, or err=1 if flagged (done=0 on error); go to IDLE.
- No bubbles: every non-IDLE/FIN cycle with out_ready=1 retires exactly one instruction.
- Instruction count for imm > 0 = 3 + popcount(imm) + msb_index(imm).
- Encodings:
  - R-type: {opcode[6:0], rd, rs1, rs2, zero pad}.
  - MOV: {MOV_OP, rd, 5'b0, 16'b0}.
  - LSL: {LSL_OP, rd, rs1, 4'b0, pad, shamt = 1 in bits [4:0]}.
  - NOP: {5'b11001, 0}.
- req_valid is ignored while busy; it must be held by ID until accepted.

Optional Feature:
- Macro: UCODE_SIGNED_IMM_EN.
- With the macro: immediate is two's complement. On accept, imm_q = |imm| and a neg flag is latched. After the last ADD (or after CLRD when imm = 0), if neg: emit MOV T,#0, then SUB Rd,T,Rd, then go to FIN.
  - Example: imm = -3 gives Rd = -3·Rs.
  - Most-negative imm: magnitude is taken in IMM_W+1 bits.
- Without the macro: immediate is unsigned and the NEG states are absent.

Decomposition:
- Package ucode_pkg:
  - opcode constants MOV_OP=7'b0000000, ADD_OP=7'b0110001, SUB_OP=7'b0110010, LSL_OP=7'b0110100, NOP word;
  - state enum;
  - encode functions enc_rrr(op, rd, rs1, rs2), enc_movi(rd, imm), enc_lsl(rd, rs, sh).
- Sub-module ucode_out_hold: a 1-entry output register with valid/ready that decouples the FSM from stalls. Optional; an inline hold is acceptable.

Test Plan:
- Rd=1, Rs=2, imm=3, out_ready=1 → MOV R15,0; ADD R15,R15,R2; MOV R1,0; ADD R1,R1,R15; LSL R15,R15,1; ADD R1,R1,R15; then done; 6 valid cycles.
- imm=0, Rd=4 → single MOV R4,0, then done; req_ready returns high the cycle after done.
- imm=5 with out_ready low for 3 cycles during the first LSL → LSL held stable; sequence MOV,ADD,MOV,ADD,LSL,LSL,ADD unchanged.
- Rd=Rs=3, imm=0x8000 → 3 + 1 + 15 = 19 instructions; register model gives R3 = old_R3·32768 mod 2^32.
- Rd=15 → no out_valid, err pulse, done=0; rst asserted mid-sequence → out_valid=0 and mux_sel=0 immediately, IDLE.
- With UCODE_SIGNED_IMM_EN, imm=-2, Rs=7 → trailing MOV R15,0; SUB Rd,R15,Rd; Rd=-14.

Source files
------------

// File: rtl/ucode_pkg.sv
// -----------------------------------------------------------------------------
// ucode_pkg
//   Shared definitions for the MUL microcode sequencer:
//     - instruction field widths and opcode constants
//     - the NOP word driven whenever no generated instruction is valid
//     - the sequencer state enumeration
//     - encoders for the three instruction shapes the sequencer emits
//   Field layout (REG_BITS = 4, INSN_BITS = 32):
//     R-type : {op[6:0], rd, rs1, rs2, 13'b0}
//     MOV    : {MOV_OP, rd, 5'b0, imm[15:0]}
//     LSL    : {LSL_OP, rd, rs1, 4'b0, 8'b0, shamt[4:0]}
//     NOP    : {5'b11001, 27'b0}
// -----------------------------------------------------------------------------
package ucode_pkg;

  localparam int INSN_BITS = 32;
  localparam int REG_BITS  = 4;
  localparam int OP_BITS   = 7;

  // Zero padding that fills out the shorter instruction shapes.
  localparam int RRR_PAD = INSN_BITS - OP_BITS - 3 * REG_BITS;
  localparam int LSL_PAD = INSN_BITS - OP_BITS - 3 * REG_BITS - 5;

  typedef logic [INSN_BITS-1:0] insn_t;
  typedef logic [REG_BITS-1:0]  reg_idx_t;
  typedef logic [OP_BITS-1:0]   opcode_t;

  localparam opcode_t MOV_OP = 7'b0000000;
  localparam opcode_t ADD_OP = 7'b0110001;
  localparam opcode_t SUB_OP = 7'b0110010;
  localparam opcode_t LSL_OP = 7'b0110100;

  localparam insn_t NOP_INSN = {5'b11001, {(INSN_BITS - 5){1'b0}}};

  // ST_NEG_* are only reachable when signed immediates are enabled.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLRT,
    ST_CPYT,
    ST_CLRD,
    ST_ADD,
    ST_SHL,
    ST_NEG_CLR,
    ST_NEG_SUB,
    ST_FIN
  } state_t;

  function automatic insn_t enc_rrr(input opcode_t  op,
                                    input reg_idx_t rd,
                                    input reg_idx_t rs1,
                                    input reg_idx_t rs2);
    return {op, rd, rs1, rs2, {RRR_PAD{1'b0}}};
  endfunction

  function automatic insn_t enc_movi(input reg_idx_t    rd,
                                     input logic [15:0] imm);
    return {MOV_OP, rd, 5'b00000, imm};
  endfunction

  function automatic insn_t enc_lsl(input reg_idx_t   rd,
                                    input reg_idx_t   rs,
                                    input logic [4:0] sh);
    return {LSL_OP, rd, rs, {REG_BITS{1'b0}}, {LSL_PAD{1'b0}}, sh};
  endfunction

  // A state drives a real instruction into the pipeline (and owns the mux).
  function automatic logic is_emit(input state_t st);
    return (st != ST_IDLE) && (st != ST_FIN);
  endfunction

endpackage

// File: rtl/ucode_mul_seq.sv
// -----------------------------------------------------------------------------
// ucode_mul_seq
//   Expands `MUL Rd, Rs, #imm` into a shift-and-add stream of simple ALU
//   instructions that replaces the fetch stream while it runs. The shifted
//   multiplicand lives in the reserved scratch register T (SCRATCH_REG), so
//   the stream length grows with the immediate's bit width, not its value.
//
//   Ports:
//     clk, rst      clock; asynchronous active-high reset (aborts a sequence,
//                   the partially written Rd is left as is)
//     req_valid     ID presents a decoded MUL (held until accepted)
//     req_ready     sequencer idle and able to accept
//     dest_reg      Rd, sampled on accept
//     source_reg    Rs, sampled on accept
//     immediate     multiplier, sampled on accept
//     out_insn      generated instruction, NOP when out_valid = 0
//     out_valid     out_insn is a real instruction
//     out_ready     pipeline takes out_insn this cycle (low = stall)
//     mux_sel       pipeline selects out_insn instead of the fetch stream
//     done          one-cycle pulse when a sequence completes
//     err           one-cycle pulse when a request names T as Rd or Rs
//
//   Build option:
//     UCODE_SIGNED_IMM_EN  immediate is two's complement; the magnitude is
//                          multiplied and the product negated at the end with
//                          MOV T,#0 ; SUB Rd,T,Rd.
//
//   Every output is registered: the state register and the outputs are all
//   loaded from the next-state decision, so an emitting state holds its
//   instruction unchanged for as long as out_ready stays low.
// -----------------------------------------------------------------------------
module ucode_mul_seq
  import ucode_pkg::*;
#(
  parameter int IMM_W       = 16,
  parameter int REG_W       = REG_BITS,
  parameter int INSN_W      = INSN_BITS,
  parameter int SCRATCH_REG = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [REG_W-1:0]  dest_reg,
  input  logic [REG_W-1:0]  source_reg,
  input  logic [IMM_W-1:0]  immediate,
  output logic [INSN_W-1:0] out_insn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              mux_sel,
  output logic              done,
  output logic              err
);

  localparam reg_idx_t T_REG = reg_idx_t'(SCRATCH_REG);

`ifdef UCODE_SIGNED_IMM_EN
  // One extra bit so the magnitude of the most negative immediate fits.
  localparam int MAG_W = IMM_W + 1;
`else
  localparam int MAG_W = IMM_W;
`endif

  state_t           state;
  state_t           nxt;
  state_t           tail_st;
  reg_idx_t         d_q;
  reg_idx_t         s_q;
  reg_idx_t         rd_sel;
  reg_idx_t         rs_sel;
  logic [MAG_W-1:0] imm_q;
  logic [MAG_W-1:0] acc_mag;
  logic             accept;
  logic             bad_reg;
  logic             flag_err;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign bad_reg   = (reg_idx_t'(dest_reg) == T_REG) ||
                     (reg_idx_t'(source_reg) == T_REG);

`ifdef UCODE_SIGNED_IMM_EN
  logic             neg_q;
  logic             acc_neg;
  logic [MAG_W-1:0] imm_sext;

  assign imm_sext = {immediate[IMM_W-1], immediate};
  assign acc_neg  = immediate[IMM_W-1];
  assign acc_mag  = acc_neg ? (~imm_sext + MAG_W'(1)) : imm_sext;
  // After the last multiply step a negative request detours through the
  // negation pair before finishing.
  assign tail_st  = neg_q ? ST_NEG_CLR : ST_FIN;
`else
  assign acc_mag  = immediate;
  assign tail_st  = ST_FIN;
`endif

  // The instruction loaded on the accept edge is built from the request
  // ports, because the latched copies are written on that same edge.
  assign rd_sel = accept ? reg_idx_t'(dest_reg)   : d_q;
  assign rs_sel = accept ? reg_idx_t'(source_reg) : s_q;

  // Instruction driven while sitting in a given state.
  function automatic insn_t emit_insn(input state_t   st,
                                      input reg_idx_t rd,
                                      input reg_idx_t rs);
    case (st)
      ST_CLRT:    return enc_movi(T_REG, 16'h0000);
      ST_CPYT:    return enc_rrr(ADD_OP, T_REG, T_REG, rs);
      ST_CLRD:    return enc_movi(rd, 16'h0000);
      ST_ADD:     return enc_rrr(ADD_OP, rd, rd, T_REG);
      ST_SHL:     return enc_lsl(T_REG, T_REG, 5'd1);
      ST_NEG_CLR: return enc_movi(T_REG, 16'h0000);
      ST_NEG_SUB: return enc_rrr(SUB_OP, rd, T_REG, rd);
      default:    return NOP_INSN;
    endcase
  endfunction

  // Next-state decision. Emitting states only move on when the pipeline
  // takes the current instruction.
  // NOTE: every variable assigned in this block gets a default first, so no
  // path leaves it holding its old value and no latch is inferred.
  always_comb begin
    nxt      = state;
    flag_err = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (bad_reg) begin
            nxt      = ST_FIN;
            flag_err = 1'b1;
          end else if (acc_mag == '0) begin
            nxt = ST_CLRD;
          end else begin
            nxt = ST_CLRT;
          end
        end
      end
      ST_CLRT: if (out_ready) nxt = ST_CPYT;
      // T is a private copy of Rs from here on, so Rd == Rs is harmless.
      ST_CPYT: if (out_ready) nxt = ST_CLRD;
      ST_CLRD: begin
        if (out_ready) begin
          if (imm_q == '0)   nxt = tail_st;
          else if (imm_q[0]) nxt = ST_ADD;
          else               nxt = ST_SHL;
        end
      end
      ST_ADD: begin
        if (out_ready) nxt = (imm_q[MAG_W-1:1] == '0) ? tail_st : ST_SHL;
      end
      // imm_q[1] becomes bit 0 once this shift retires.
      ST_SHL: if (out_ready) nxt = imm_q[1] ? ST_ADD : ST_SHL;
`ifdef UCODE_SIGNED_IMM_EN
      ST_NEG_CLR: if (out_ready) nxt = ST_NEG_SUB;
      ST_NEG_SUB: if (out_ready) nxt = ST_FIN;
`endif
      ST_FIN:  nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // State, request latches and all outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      d_q       <= '0;
      s_q       <= '0;
      imm_q     <= '0;
`ifdef UCODE_SIGNED_IMM_EN
      neg_q     <= 1'b0;
`endif
      out_insn  <= INSN_W'(NOP_INSN);
      out_valid <= 1'b0;
      mux_sel   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= nxt;

      if (accept) begin
        d_q   <= reg_idx_t'(dest_reg);
        s_q   <= reg_idx_t'(source_reg);
        imm_q <= acc_mag;
`ifdef UCODE_SIGNED_IMM_EN
        neg_q <= acc_neg;
`endif
      end else if ((state == ST_SHL) && out_ready) begin
        imm_q <= imm_q >> 1;
      end

      out_insn  <= INSN_W'(emit_insn(nxt, rd_sel, rs_sel));
      out_valid <= is_emit(nxt);
      mux_sel   <= is_emit(nxt);
      done      <= (nxt == ST_FIN) && !flag_err;
      err       <= flag_err;
    end
  end

endmodule

// File: tb/tb_ucode_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_ucode_mul_seq
//   Self-checking bench for ucode_mul_seq. A queue holds the instruction
//   stream each request must produce, derived from the multiplier's bits; a
//   register-file model executes every retired instruction so the final Rd is
//   compared against plain multiplication. A negedge monitor compares the
//   outputs every cycle. Literal values pin the encodings and a few products.
// -----------------------------------------------------------------------------
module tb_ucode_mul_seq;

  localparam logic [31:0] NOP = 32'hC800_0000;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  dest_reg;
  logic [3:0]  source_reg;
  logic [15:0] immediate;
  logic [31:0] out_insn;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        mux_sel;
  logic        done;
  logic        err;

  ucode_mul_seq #(
    .IMM_W      (16),
    .REG_W      (4),
    .INSN_W     (32),
    .SCRATCH_REG(15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .dest_reg  (dest_reg),
    .source_reg(source_reg),
    .immediate (immediate),
    .out_insn  (out_insn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mux_sel   (mux_sel),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_q[$];
  logic [31:0] log_q[$];
  logic [31:0] regs[16];
  int          retired     = 0;
  int          stall_idx   = -1;
  int          stall_left  = 0;
  int          stall_every = 0;
  int          cyc         = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
  endtask

  // Independent encoders written straight from the instruction layouts.
  function automatic logic [31:0] f_mov(input logic [3:0] rd);
    return {7'b0000000, rd, 5'b0, 16'b0};
  endfunction
  function automatic logic [31:0] f_add(input logic [3:0] rd, a, b);
    return {7'b0110001, rd, a, b, 13'b0};
  endfunction
  function automatic logic [31:0] f_sub(input logic [3:0] rd, a, b);
    return {7'b0110010, rd, a, b, 13'b0};
  endfunction
  function automatic logic [31:0] f_lsl(input logic [3:0] rd, a);
    return {7'b0110100, rd, a, 4'b0, 8'b0, 5'd1};
  endfunction

  function automatic int imm_value(input logic [15:0] imm);
`ifdef UCODE_SIGNED_IMM_EN
    return int'($signed(imm));
`else
    return int'({16'b0, imm});
`endif
  endfunction

  // Register-file model: execute one retired instruction.
  function automatic void exec(input logic [31:0] insn);
    logic [3:0] rd, a, b;
    rd = insn[24:21];
    a  = insn[20:17];
    b  = insn[16:13];
    case (insn[31:25])
      7'b0000000: regs[rd] = {16'b0, insn[15:0]};
      7'b0110001: regs[rd] = regs[a] + regs[b];
      7'b0110010: regs[rd] = regs[a] - regs[b];
      7'b0110100: regs[rd] = regs[a] << insn[4:0];
      default: ;
    endcase
  endfunction

  // Shift-and-add stream for Rd = Rs * imm: walk the magnitude's bits from
  // LSB to MSB, doubling T between bits and adding T wherever a bit is set.
  function automatic void build_exp(input logic [3:0] rd, rs,
                                    input logic [15:0] imm);
    int          v;
    int          msb;
    logic [31:0] mag;
    exp_q.delete();
    if (rd == 4'd15 || rs == 4'd15) return;
    v   = imm_value(imm);
    mag = (v < 0) ? 32'(-v) : 32'(v);
    if (mag == 0) begin
      exp_q.push_back(f_mov(rd));
    end else begin
      exp_q.push_back(f_mov(4'd15));
      exp_q.push_back(f_add(4'd15, 4'd15, rs));
      exp_q.push_back(f_mov(rd));
      msb = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
      for (int i = 0; i <= msb; i++) begin
        if (i > 0) exp_q.push_back(f_lsl(4'd15, 4'd15));
        if (mag[i]) exp_q.push_back(f_add(rd, rd, 4'd15));
      end
    end
    if (v < 0) begin
      exp_q.push_back(f_mov(4'd15));
      exp_q.push_back(f_sub(rd, 4'd15, rd));
    end
  endfunction

  // Per-cycle compare: while instructions are owed, the DUT must present the
  // head of the queue with no bubbles; otherwise it must be idle on a NOP.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() != 0) begin
        check("out_valid_busy", 32'(out_valid), 32'd1);
        check("mux_sel_busy", 32'(mux_sel), 32'd1);
        check("out_insn", out_insn, exp_q[0]);
        if (out_ready && out_valid) begin
          exec(out_insn);
          log_q.push_back(out_insn);
          void'(exp_q.pop_front());
          retired++;
        end
      end else begin
        check("out_valid_idle", 32'(out_valid), 32'd0);
        check("mux_sel_idle", 32'(mux_sel), 32'd0);
        check("out_insn_nop", out_insn, NOP);
      end
    end
  end

  // Pipeline back-pressure: a directed stall window at one retire index
  // and/or a periodic stall.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (stall_left > 0 && retired == stall_idx && exp_q.size() != 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else if (stall_every > 0 && (cyc % stall_every) == 0) begin
      out_ready = 1'b0;
    end else begin
      out_ready = 1'b1;
    end
  end

  task automatic issue(input logic [3:0] rd, rs, input logic [15:0] imm);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (req_ready !== 1'b1) check("req_ready_wait", 32'(req_ready), 32'd1);
    dest_reg   = rd;
    source_reg = rs;
    immediate  = imm;
    req_valid  = 1'b1;
    @(posedge clk);
    build_exp(rd, rs, imm);
    retired = 0;
    log_q.delete();
    #1 req_valid = 1'b0;
  endtask

  task automatic run_mul(input string tag, input logic [3:0] rd, rs,
                         input logic [15:0] imm, input bit noisy);
    logic [31:0] rs_val;
    logic [31:0] want;
    logic [31:0] mag;
    int          v, n, pop, msb, cnt;
    rs_val = regs[rs];
    v      = imm_value(imm);
    want   = rs_val * 32'(v);
    mag    = (v < 0) ? 32'(-v) : 32'(v);
    pop    = 0;
    msb    = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) begin pop++; msb = i; end
    cnt = (mag == 0) ? 1 : 3 + pop + msb;
    if (v < 0) cnt += 2;

    issue(rd, rs, imm);
    if (noisy) begin
      // A second request while busy must be ignored.
      dest_reg   = 4'd9;
      source_reg = 4'd10;
      immediate  = 16'h0007;
      req_valid  = 1'b1;
      repeat (4) @(posedge clk);
      #1 req_valid = 1'b0;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      return;
    end
    #1;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_ready_fin"}, 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    check({tag, "_count"}, 32'(retired), 32'(cnt));
    check({tag, "_result"}, regs[rd], want);
  endtask

  task automatic run_err(input string tag, input logic [3:0] rd, rs);
    issue(rd, rs, 16'd3);
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_err_pulse"}, 32'(err), 32'd0);
    check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    check({tag, "_count"}, 32'(retired), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst        = 1'b1;
    req_valid  = 1'b0;
    dest_reg   = '0;
    source_reg = '0;
    immediate  = '0;
    for (int i = 0; i < 16; i++) regs[i] = 32'h100 + 32'(i);

    // Reset state.
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_insn", out_insn, 32'hC800_0000);
    check("rst_mux", 32'(mux_sel), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    #11 rst = 1'b0;
    @(posedge clk);
    #1;

    // Rd=1, Rs=2, imm=3.
    regs[2] = 32'd7;
    run_mul("imm3", 4'd1, 4'd2, 16'd3, 1'b0);
    check("imm3_len", 32'(log_q.size()), 32'd6);
    check("imm3_i0", log_q[0], 32'h01E0_0000);
    check("imm3_i1", log_q[1], 32'h63FE_4000);
    check("imm3_i2", log_q[2], 32'h0020_0000);
    check("imm3_i3", log_q[3], 32'h6223_E000);
    check("imm3_i4", log_q[4], 32'h69FE_0001);
    check("imm3_i5", log_q[5], 32'h6223_E000);
    check("imm3_lit", regs[1], 32'd21);

    // imm=0: a single MOV Rd,#0.
    regs[4] = 32'hDEAD_BEEF;
    run_mul("imm0", 4'd4, 4'd2, 16'd0, 1'b0);
    check("imm0_i0", log_q[0], 32'h0080_0000);

    // imm=5 with a 3-cycle stall on the first LSL.
    stall_idx  = 4;
    stall_left = 3;
    run_mul("imm5", 4'd1, 4'd2, 16'd5, 1'b0);
    check("imm5_len", 32'(log_q.size()), 32'd7);
    check("imm5_stall_used", 32'(stall_left), 32'd0);
    check("imm5_lit", regs[1], 32'd35);
    stall_idx = -1;

    // Rd == Rs, top bit only, periodic stalls and a request while busy.
    regs[3]     = 32'h0001_2345;
    stall_every = 3;
    run_mul("msb", 4'd3, 4'd3, 16'h8000, 1'b1);
    stall_every = 0;
`ifdef UCODE_SIGNED_IMM_EN
    check("msb_lit", regs[3], 32'h6E5D_8000);
`else
    check("msb_lit", regs[3], 32'h91A2_8000);
`endif

    // All ones.
    regs[6] = 32'd3;
    run_mul("ones", 4'd2, 4'd6, 16'hFFFF, 1'b0);

    // Requests naming the scratch register.
    run_err("bad_rd", 4'd15, 4'd2);
    run_err("bad_rs", 4'd1, 4'd15);

`ifdef UCODE_SIGNED_IMM_EN
    regs[5] = 32'd7;
    run_mul("neg2", 4'd1, 4'd5, 16'hFFFE, 1'b0);
    check("neg2_lit", regs[1], 32'hFFFF_FFF2);
    check("neg2_i5", log_q[5], 32'h01E0_0000);
    check("neg2_i6", log_q[6], 32'h643E_2000);
`endif

    // Reset in the middle of a sequence.
    issue(4'd5, 4'd2, 16'h00FF);
    n = 0;
    while (retired < 3 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (retired < 3) check("mid_rst_progress", 32'(retired), 32'd3);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_mux", 32'(mux_sel), 32'd0);
    check("mid_rst_insn", out_insn, NOP);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    exp_q.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Normal operation after the abort.
    regs[6] = 32'd11;
    run_mul("recover", 4'd5, 4'd6, 16'h00A5, 1'b0);
    check("recover_lit", regs[5], 32'd1815);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
